// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor. The WIDTH-bit carry chain is cut into STAGES
// registered slices of SW = WIDTH/STAGES bits. Each stage resolves one slice
// using the carry registered by the stage before it. Still-unprocessed operand
// slices and already-finished sum slices travel down the pipe with the beat.
// The final stage registers the full result together with its flags. A single
// stall signal freezes the whole pipe, so every stage's valid bit and data
// hold together.
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int SW = WIDTH / STAGES;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ADC = 2'b10,
    MODE_SBC = 2'b11
  } mode_e;

  // Per-stage pipeline state. a_q/b_q hold the operands, and only the slices
  // above the stage's own slice are still meaningful. sum_q holds the finished
  // low slices. carry_q feeds the next stage.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // Flags belong to the output register and are produced from the full sum.
  logic cout_q, cout_d;
  logic ovf_q,  ovf_d;
  logic zero_q, zero_d;
  logic neg_q,  neg_d;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;

  // The output is held while the consumer refuses it, and the whole pipe freezes with it.
  assign stall     = valid_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;

  // Operand conditioning: subtract modes invert B, and the mode selects the carry-in.
  always_comb begin
    b_eff = in_mode[0] ? ~in_b : in_b;
    unique case (mode_e'(in_mode))
      MODE_ADD: c0 = 1'b0;
      MODE_SUB: c0 = 1'b1;
      default:  c0 = in_cin;   // ADC and SBC take the external carry
    endcase
  end

  // Slice datapath: stage k adds slice k of its incoming beat. After the loop,
  // the temporaries hold the last stage's view, which the flags are derived from.
  always_comb begin : p_datapath
    logic [WIDTH-1:0] a_cur;
    logic [WIDTH-1:0] b_cur;
    logic [WIDTH-1:0] s_cur;
    logic             c_cur;
    logic [SW:0]      slice;
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    a_cur   = in_a;
    b_cur   = b_eff;
    s_cur   = '0;
    c_cur   = c0;
    slice   = '0;
    valid_d = '0;
    carry_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_cur      = in_a;
        b_cur      = b_eff;
        s_cur      = '0;
        c_cur      = c0;
        valid_d[k] = in_valid;
      end else begin
        a_cur      = a_q[k-1];
        b_cur      = b_q[k-1];
        s_cur      = sum_q[k-1];
        c_cur      = carry_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      slice = {1'b0, a_cur[k*SW +: SW]} + {1'b0, b_cur[k*SW +: SW]} + {{SW{1'b0}}, c_cur};
      s_cur[k*SW +: SW] = slice[SW-1:0];
      a_d[k]     = a_cur;
      b_d[k]     = b_cur;
      sum_d[k]   = s_cur;
      carry_d[k] = slice[SW];
    end
    cout_d = carry_d[STAGES-1];
    ovf_d  = (a_cur[WIDTH-1] == b_cur[WIDTH-1]) && (s_cur[WIDTH-1] != a_cur[WIDTH-1]);
    zero_d = (s_cur == '0);
    neg_d  = s_cur[WIDTH-1];
  end

  // Pipeline registers: advance together unless stalled. Data loads only with a valid beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are cleared too, because the output word and flags must read 0 in reset.
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments let every stage see last cycle's neighbour values.
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        if (valid_d[k]) begin
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
      if (valid_d[STAGES-1]) begin
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub. It runs four instances (STAGES = 4, 1, 2, 16)
// side by side on shared stimulus. Directed vectors and sequences target the
// STAGES=4 instance. Every instance is scoreboarded against an arithmetic
// reference model on every output handshake.
module tb_pipelined_add_sub;

  localparam int W = 16;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_cin;
  logic        out_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_a;
  logic [15:0] in_b;

  logic [3:0]  rdy, ovl, ocout, oovf, ozero, oneg;
  logic [15:0] osum [4];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned and signed integer arithmetic on whole operands.
  // Result is {cout, ovf, zero, neg, sum}.
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic [1:0] mode);
    int ua, ub, sa, sb, c, u, s;
    logic [15:0] r;
    logic        cout, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = (mode == 2'b00) ? 0 : (mode == 2'b01) ? 1 : int'(cin);
    if (!mode[0]) begin
      u    = ua + ub + c;
      s    = sa + sb + c;
      cout = (u > 65535);
    end else begin
      u    = ua - ub - 1 + c;
      s    = sa - sb - 1 + c;
      cout = (u >= 0);
    end
    r   = u[15:0];
    ovf = (s > 32767) || (s < -32768);
    return {cout, ovf, (r == 16'h0000), r[15], r};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int S = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : 16;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy[i]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_mode   (in_mode),
      .out_valid (ovl[i]),
      .out_ready (out_ready),
      .out_sum   (osum[i]),
      .out_cout  (ocout[i]),
      .out_ovf   (oovf[i]),
      .out_zero  (ozero[i]),
      .out_neg   (oneg[i])
    );

    logic [19:0] exp_q [$];
    int          pending = 0;

    // Scoreboard: samples handshakes mid-cycle, so the decisions match the next rising edge.
    always @(negedge clk) begin
      logic [19:0] e;
      if (reset) begin
        exp_q.delete();
      end else begin
        if (ovl[i] && out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("s%0d_spurious_out", S), 32'(ovl[i]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("s%0d_beat", S),
                  {12'd0, ocout[i], oovf[i], ozero[i], oneg[i], osum[i]}, {12'd0, e});
          end
        end
        if (in_valid && rdy[i]) exp_q.push_back(ref_model(in_a, in_b, in_cin, in_mode));
      end
      pending = exp_q.size();
    end
  end

  // Single beat into an idle pipe: latency counted in edges including acceptance, then one-beat pulse.
  task automatic apply_vec(input vec_t v);
    int edges;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_cin    = v.cin;
    in_mode   = v.mode;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!ovl[0] && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({v.name, "_latency"}, 32'(edges), 32'd4);
    check({v.name, "_sum"},  32'(osum[0]),  32'(v.sum));
    check({v.name, "_cout"}, 32'(ocout[0]), 32'(v.cout));
    check({v.name, "_ovf"},  32'(oovf[0]),  32'(v.ovf));
    check({v.name, "_zero"}, 32'(ozero[0]), 32'(v.zero));
    check({v.name, "_neg"},  32'(oneg[0]),  32'(v.neg));
    @(posedge clk); #1;
    check({v.name, "_single"}, 32'(ovl[0]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    int          beat, got;
    logic [15:0] held;

    vecs[0] = '{"add_00ff_1",  2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"sub_0_1",     2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"sub_8000_1",  2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"add_7fff_1",  2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"adc_ffff_c1", 2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"sbc_5_3_c0",  2'b11, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"add_wrap",    2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"sbc_5_3_c1",  2'b11, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ovl), 32'd0);
    check("rst_in_ready",  32'(rdy), 32'hF);
    check("rst_out_sum",   32'(osum[0]), 32'd0);
    check("rst_flags",     32'({ocout[0], oovf[0], ozero[0], oneg[0]}), 32'd0);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Stream of 8 ADDs with a 3-cycle output stall mid-stream
    beat = 0;
    got  = 0;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (beat < 8);
      in_a      = 16'(beat);
      in_b      = 16'h1000;
      in_cin    = 1'b0;
      in_mode   = 2'b00;
      out_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge clk);
      check($sformatf("stream_in_ready_c%0d", cyc), 32'(rdy[0]), (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
      if (cyc == 5) held = osum[0];
      if (cyc == 6 || cyc == 7) begin
        check("stream_hold_sum",   32'(osum[0]), 32'(held));
        check("stream_hold_valid", 32'(ovl[0]),  32'd1);
      end
      if (ovl[0] && out_ready) begin
        check($sformatf("stream_result_%0d", got), 32'(osum[0]), 32'h1000 + 32'(got));
        got++;
      end
      if (in_valid && rdy[0]) beat++;
    end
    check("stream_count", 32'(got), 32'd8);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);

    // Reset with three beats in flight and the output held
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = 16'h0100 * 16'(j + 1);
      in_b     = 16'h0011;
      in_mode  = 2'b00;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("inflight_out_valid", 32'(ovl[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(ovl), 32'd0);
    check("async_rst_out_sum",   32'(osum[0]), 32'd0);
    check("async_rst_flags",     32'({ocout[0], oovf[0], ozero[0], oneg[0]}), 32'd0);
    check("async_rst_in_ready",  32'(rdy), 32'hF);
    @(posedge clk);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(ovl), 32'd0);
    end
    apply_vec(vecs[0]);
    repeat (20) @(posedge clk);

    // Random traffic on all instances
    for (int c = 0; c < 18000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 99) < 70);
      in_a      = pick();
      in_b      = pick();
      in_cin    = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < 75);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("s4_drained",  32'(g_dut[0].pending), 32'd0);
    check("s1_drained",  32'(g_dut[1].pending), 32'd0);
    check("s2_drained",  32'(g_dut[2].pending), 32'd0);
    check("s16_drained", 32'(g_dut[3].pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
